// File: rtl/sdram_line_fetcher.sv
// Purpose : fetches one scan line of H_RES 16-bit words through the SDRAM controller burst FIFOs,
//           issuing 8-word burst reads and unpacking the 128-bit results into a pixel stream.
// Latency : first burst command 2 cycles after line_start_i; first pixel valid 1 cycle after the data FIFO goes non-empty.
// Backpressure: pix_ready_i low freezes pix_o/pix_valid_o and the drain side; command issue waits on
//           cmd_burst_full_i and on MAX_OUTSTANDING in-flight bursts.
// Ports   : clk/rst_n_i; line_start_i/line_addr_i request, busy_o/line_done_o/overrun_o status;
//           cmd_burst_* command FIFO write side; data_burst_* FWFT data FIFO read side;
//           pix_o/pix_valid_o/pix_ready_i pixel stream.
module sdram_line_fetcher #(
    parameter int H_RES           = 640,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic         clk,
    input  logic         rst_n_i,
    input  logic         line_start_i,
    input  logic [23:0]  line_addr_i,
    output logic         busy_o,
    output logic         line_done_o,
    output logic         overrun_o,
    output logic [31:0]  cmd_burst_d_o,
    output logic         cmd_burst_enq_o,
    input  logic         cmd_burst_full_i,
    input  logic [127:0] data_burst_q_i,
    output logic         data_burst_deq_o,
    input  logic         data_burst_empty_i,
    output logic [15:0]  pix_o,
    output logic         pix_valid_o,
    input  logic         pix_ready_i
);

    localparam int BURSTS = H_RES / 8;
    localparam int ISS_W  = $clog2(BURSTS + 1);
    localparam int PIX_W  = $clog2(H_RES + 1);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [ISS_W-1:0] BURSTS_V   = ISS_W'(BURSTS);
    localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(H_RES - 1);
    localparam logic [OUT_W-1:0] MAX_OUT_V  = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        addr_q;
    logic [ISS_W-1:0]   issued_q;
    logic [ISS_W-1:0]   popped_q;
    logic [PIX_W-1:0]   pix_cnt_q;
    logic [OUT_W-1:0]   outstanding_q;
    logic [127:0]       pix_buf_q;
    logic [3:0]         cnt_q;
    logic               enq_q, deq_q, done_q, overrun_q;
    logic [31:0]        cmd_q;

    logic               start, last_hs, pix_hs, enq_next, deq_next;

    // Line addresses are burst aligned; the low bits are deliberately ignored.
    logic               unused_addr_lsbs;
    assign unused_addr_lsbs = ^line_addr_i[2:0];

    assign pix_o            = pix_buf_q[127:112];
    assign pix_valid_o      = (cnt_q != 4'd0);
    assign pix_hs           = pix_valid_o && pix_ready_i;
    assign busy_o           = (state_q == FETCH);
    assign line_done_o      = done_q;
    assign overrun_o        = overrun_q;
    assign cmd_burst_d_o    = cmd_q;
    assign cmd_burst_enq_o  = enq_q;
    assign data_burst_deq_o = deq_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        last_hs  = 1'b0;
        enq_next = 1'b0;
        deq_next = 1'b0;
        case (state_q)
            IDLE: begin
                if (line_start_i) begin
                    start   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // enq_q in the decision keeps commands at most every other cycle.
                enq_next = (issued_q < BURSTS_V) && (outstanding_q < MAX_OUT_V) &&
                           !cmd_burst_full_i && !enq_q;
                // The FIFO head is captured at the decision edge and popped the
                // following cycle, so a just-popped entry is never taken twice.
                deq_next = (cnt_q == 4'd0) && !data_burst_empty_i && !deq_q &&
                           (outstanding_q != '0) && (popped_q < BURSTS_V);
                if (pix_hs && (pix_cnt_q == LAST_PIX)) begin
                    last_hs = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q        <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            pix_cnt_q     <= '0;
            outstanding_q <= '0;
            pix_buf_q     <= '0;
            cnt_q         <= '0;
            enq_q         <= 1'b0;
            deq_q         <= 1'b0;
            done_q        <= 1'b0;
            overrun_q     <= 1'b0;
            cmd_q         <= '0;
        end else begin
            enq_q  <= enq_next;
            deq_q  <= deq_next;
            done_q <= last_hs;
            if (line_start_i && (state_q == FETCH)) begin
                overrun_q <= 1'b1;
            end
            if (start) begin
                addr_q        <= {line_addr_i[23:3], 3'b000};
                issued_q      <= '0;
                popped_q      <= '0;
                pix_cnt_q     <= '0;
                outstanding_q <= '0;
                cnt_q         <= '0;
            end else begin
                if (enq_next) begin
                    cmd_q    <= {8'h00, addr_q};
                    addr_q   <= addr_q + 24'd8;
                    issued_q <= issued_q + ISS_W'(1);
                end
                case ({enq_next, deq_next})
                    2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
                    2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
                    default: outstanding_q <= outstanding_q;
                endcase
                // A load only happens with cnt==0, so it never collides with a handshake.
                if (deq_next) begin
                    pix_buf_q <= data_burst_q_i;
                    cnt_q     <= 4'd8;
                    popped_q  <= popped_q + ISS_W'(1);
                end else if (pix_hs) begin
                    pix_buf_q <= {pix_buf_q[111:0], 16'h0000};
                    cnt_q     <= cnt_q - 4'd1;
                    pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_line_fetcher.sv
// Purpose : self-checking bench for sdram_line_fetcher with a burst FIFO / SDRAM model.
// Latency : model returns bursts 0..3 cycles after the command is enqueued.
// Backpressure: pixel ready is driven constant, random or stalled per test step.
module tb_sdram_line_fetcher;

    localparam int H    = 48;
    localparam int MAXO = 4;
    localparam int NB   = H / 8;

    logic         clk = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         line_start_i = 1'b0;
    logic [23:0]  line_addr_i = '0;
    logic         busy_o, line_done_o, overrun_o;
    logic [31:0]  cmd_burst_d_o;
    logic         cmd_burst_enq_o;
    logic         cmd_burst_full_i = 1'b0;
    logic [127:0] data_burst_q_i = '0;
    logic         data_burst_deq_o;
    logic         data_burst_empty_i = 1'b1;
    logic [15:0]  pix_o;
    logic         pix_valid_o;
    logic         pix_ready_i = 1'b0;

    always #5 clk = ~clk;

    sdram_line_fetcher #(.H_RES(H), .MAX_OUTSTANDING(MAXO)) dut (
        .clk                (clk),
        .rst_n_i            (rst_n_i),
        .line_start_i       (line_start_i),
        .line_addr_i        (line_addr_i),
        .busy_o             (busy_o),
        .line_done_o        (line_done_o),
        .overrun_o          (overrun_o),
        .cmd_burst_d_o      (cmd_burst_d_o),
        .cmd_burst_enq_o    (cmd_burst_enq_o),
        .cmd_burst_full_i   (cmd_burst_full_i),
        .data_burst_q_i     (data_burst_q_i),
        .data_burst_deq_o   (data_burst_deq_o),
        .data_burst_empty_i (data_burst_empty_i),
        .pix_o              (pix_o),
        .pix_valid_o        (pix_valid_o),
        .pix_ready_i        (pix_ready_i)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents seen through the controller: a fixed function of address.
    function automatic logic [15:0] ref_word(input logic [23:0] a);
        return a[15:0] ^ {8'h5A, a[23:16]};
    endfunction

    function automatic logic [127:0] mk_burst(input logic [23:0] a);
        logic [127:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b[127-16*i -: 16] = ref_word(a + 24'(i));
        return b;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- controller-side model and monitor ----------------
    int           ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
    bit           hold_data = 1'b0;
    logic [127:0] dq[$];
    logic [23:0]  pend[$];
    logic [31:0]  cmds[$];
    logic [15:0]  got_pix[$];
    int           enq_cyc[$], vld_cyc[$], push_cyc[$];
    int           done_cnt = 0, outst = 0, lat = 0, proto_err = 0, stab_err = 0;
    bit           prev_enq = 0, prev_full = 0, prev_stall = 0, prev_vld = 0;
    logic [15:0]  prev_pix = '0;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       pix_ready_i = 1'b1;
            1:       pix_ready_i = 1'($urandom_range(0, 1));
            default: pix_ready_i = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n_i) begin
            dq.delete();
            pend.delete();
            outst = 0;
            lat = 0;
            prev_enq = 0;
            prev_full = 0;
            prev_stall = 0;
            prev_vld = 0;
        end else begin
            if (prev_stall && (!pix_valid_o || pix_o !== prev_pix)) stab_err++;
            prev_stall = pix_valid_o && !pix_ready_i;
            prev_pix = pix_o;
            if (pix_valid_o && !prev_vld) vld_cyc.push_back(cyc);
            prev_vld = pix_valid_o;
            if (pix_valid_o && pix_ready_i) got_pix.push_back(pix_o);
            if (line_done_o) done_cnt++;
            if (cmd_burst_enq_o) begin
                if (prev_enq || prev_full) proto_err++;
                enq_cyc.push_back(cyc);
                cmds.push_back(cmd_burst_d_o);
                pend.push_back(cmd_burst_d_o[23:0]);
                outst++;
            end
            prev_enq = cmd_burst_enq_o;
            prev_full = cmd_burst_full_i;
            if (data_burst_deq_o) begin
                if (dq.size() == 0) proto_err++;
                else void'(dq.pop_front());
                outst--;
            end
            if (outst > MAXO || outst < 0) proto_err++;
            if (!hold_data && pend.size() != 0) begin
                if (lat == 0) begin
                    if (dq.size() == 0) push_cyc.push_back(cyc);
                    dq.push_back(mk_burst(pend.pop_front()));
                    lat = $urandom_range(0, 3);
                end else begin
                    lat--;
                end
            end
        end
        data_burst_empty_i = (dq.size() == 0);
        data_burst_q_i = (dq.size() != 0) ? dq[0] : '0;
    end

    // ---------------- sequencing helpers ----------------
    int cmd_base, pix_base, done_base, vld_base, ne_base, start_cyc;

    // Called at negedge+1; start is held for exactly one rising edge.
    task automatic start_line(input logic [23:0] a);
        cmd_base = cmds.size();
        pix_base = got_pix.size();
        done_base = done_cnt;
        vld_base = vld_cyc.size();
        ne_base = push_cyc.size();
        start_cyc = cyc;
        line_addr_i = a;
        line_start_i = 1'b1;
        @(negedge clk); #1;
        line_start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == done_base && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_before_timeout", 64'(done_cnt != done_base), 64'd1);
    endtask

    task automatic check_line(input logic [23:0] a);
        logic [23:0] base;
        logic [31:0] gc;
        logic [15:0] gp;
        int bad;
        base = {a[23:3], 3'b000};
        chk("line_done_count", 64'(done_cnt - done_base), 64'd1);
        chk("busy_after_done", 64'(busy_o), 64'd0);
        chk("cmd_count", 64'(cmds.size() - cmd_base), 64'(NB));
        for (int k = 0; k < NB; k++) begin
            gc = (cmd_base + k < cmds.size()) ? cmds[cmd_base + k] : 32'hxxxxxxxx;
            bad = n_fail;
            chk("cmd_addr", 64'(gc), 64'({8'h00, base + 24'(8 * k)}));
            if (n_fail != bad) break;
        end
        chk("pix_count", 64'(got_pix.size() - pix_base), 64'(H));
        for (int i = 0; i < H; i++) begin
            gp = (pix_base + i < got_pix.size()) ? got_pix[pix_base + i] : 16'hxxxx;
            bad = n_fail;
            chk("pixel", 64'(gp), 64'(ref_word(base + 24'(i))));
            if (n_fail != bad) break;
        end
    endtask

    task automatic run_line(input logic [23:0] a);
        start_line(a);
        wait_done(3000);
        repeat (6) @(negedge clk);
        #1;
        check_line(a);
    endtask

    typedef struct {
        logic [23:0] addr;
        logic [31:0] cmd0;
        logic [31:0] cmd1;
        int          rmode;
    } vec_t;

    vec_t vecs[4];
    int   snap;
    logic [15:0] snap_pix;

    initial begin
        vecs[0] = '{24'h000100, 32'h00000100, 32'h00000108, 0};
        vecs[1] = '{24'hFFFFF8, 32'h00FFFFF8, 32'h00000000, 0};
        vecs[2] = '{24'h000103, 32'h00000100, 32'h00000108, 1};
        vecs[3] = '{24'h123457, 32'h00123450, 32'h00123458, 1};

        #3;
        chk("reset_outputs", 64'({busy_o, line_done_o, overrun_o, cmd_burst_enq_o, data_burst_deq_o,
                                  pix_valid_o, pix_o, cmd_burst_d_o}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk); #1;

        // Table: alignment, 24-bit wrap, latency, and full stream per line.
        for (int v = 0; v < 4; v++) begin
            ready_mode = vecs[v].rmode;
            run_line(vecs[v].addr);
            chk("tbl_cmd0", 64'((cmd_base < cmds.size()) ? cmds[cmd_base] : 32'hxxxxxxxx), 64'(vecs[v].cmd0));
            chk("tbl_cmd1", 64'((cmd_base + 1 < cmds.size()) ? cmds[cmd_base + 1] : 32'hxxxxxxxx), 64'(vecs[v].cmd1));
            chk("enq_latency", 64'((cmd_base < enq_cyc.size()) ? enq_cyc[cmd_base] - start_cyc : -1), 64'd2);
            chk("valid_latency", 64'((vld_base < vld_cyc.size() && ne_base < push_cyc.size()) ?
                                      vld_cyc[vld_base] - push_cyc[ne_base] : -1), 64'd1);
        end

        // Data never returns: outstanding limit caps issue at MAXO bursts.
        ready_mode = 0;
        hold_data = 1'b1;
        start_line(24'h004000);
        repeat (40) @(negedge clk);
        #1;
        chk("held_enq_count", 64'(cmds.size() - cmd_base), 64'(MAXO));
        chk("held_no_pixels", 64'(got_pix.size() - pix_base), 64'd0);
        hold_data = 1'b0;
        wait_done(3000);
        repeat (4) @(negedge clk);
        #1;
        check_line(24'h004000);

        // Consumer stall mid-burst, then random ready.
        ready_mode = 0;
        start_line(24'h000400);
        for (int n = 0; n < 200 && got_pix.size() - pix_base < 3; n++) begin
            @(negedge clk); #1;
        end
        ready_mode = 2;
        repeat (2) @(negedge clk);
        #1;
        snap = got_pix.size();
        snap_pix = pix_o;
        repeat (20) @(negedge clk);
        #1;
        chk("stall_no_accept", 64'(got_pix.size()), 64'(snap));
        chk("stall_valid_held", 64'(pix_valid_o), 64'd1);
        chk("stall_pix_stable", 64'(pix_o), 64'(snap_pix));
        ready_mode = 1;
        wait_done(3000);
        repeat (4) @(negedge clk);
        #1;
        check_line(24'h000400);

        // Command FIFO full blocks issue; a second start while busy is ignored.
        ready_mode = 0;
        @(posedge clk); #1;
        cmd_burst_full_i = 1'b1;
        @(negedge clk); #1;
        start_line(24'h000800);
        repeat (30) @(negedge clk);
        #1;
        chk("full_no_enq", 64'(cmds.size() - cmd_base), 64'd0);
        chk("full_busy", 64'(busy_o), 64'd1);
        chk("overrun_clear", 64'(overrun_o), 64'd0);
        line_addr_i = 24'h00ABC0;
        line_start_i = 1'b1;
        @(negedge clk); #1;
        line_start_i = 1'b0;
        @(negedge clk); #1;
        chk("overrun_set", 64'(overrun_o), 64'd1);
        @(posedge clk); #1;
        cmd_burst_full_i = 1'b0;
        wait_done(3000);
        repeat (4) @(negedge clk);
        #1;
        check_line(24'h000800);
        chk("overrun_sticky", 64'(overrun_o), 64'd1);

        // Asynchronous reset between edges mid-line.
        start_line(24'h000200);
        repeat (12) @(negedge clk);
        @(posedge clk); #3;
        rst_n_i = 1'b0;
        #1;
        chk("async_reset_outputs", 64'({busy_o, line_done_o, overrun_o, cmd_burst_enq_o, data_burst_deq_o,
                                        pix_valid_o, pix_o, cmd_burst_d_o}), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        rst_n_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("no_done_after_reset", 64'(done_cnt - done_base), 64'd0);
        run_line(24'h000300);

        // Back-to-back: new start accepted in the done cycle.
        start_line(24'h001000);
        wait_done(3000);
        check_line(24'h001000);
        start_line(24'h002008);
        chk("b2b_busy", 64'(busy_o), 64'd1);
        chk("b2b_no_overrun", 64'(overrun_o), 64'd0);
        wait_done(3000);
        repeat (4) @(negedge clk);
        #1;
        check_line(24'h002008);

        // Random addresses with random consumer ready.
        for (int r = 0; r < 3; r++) begin
            ready_mode = 1;
            run_line(24'($urandom));
        end

        chk("protocol_errors", 64'(proto_err), 64'd0);
        chk("stall_stability_errors", 64'(stab_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
